// File: rtl/cache_init_sequencer_if.sv
// Control-side bundle of the cache init sequencer: power-up/calibration/flush
// inputs and the tag RAM clear port plus status outputs.
interface cache_init_sequencer_if #(
  parameter int INDEX_WIDTH     = 8,
  parameter int TAG_ENTRY_WIDTH = 20
);
  logic                       launch;
  logic                       calib_done;
  logic                       flush_req;
  logic                       cache_idle;
  logic                       tag_we;
  logic [INDEX_WIDTH-1:0]     tag_addr;
  logic [TAG_ENTRY_WIDTH-1:0] tag_wdata;
  logic                       ready;
  logic                       flush_ack;
  logic                       calib_err;

  modport master (
    output launch, calib_done, flush_req, cache_idle,
    input  tag_we, tag_addr, tag_wdata, ready, flush_ack, calib_err
  );

  modport slave (
    input  launch, calib_done, flush_req, cache_idle,
    output tag_we, tag_addr, tag_wdata, ready, flush_ack, calib_err
  );
endinterface

// File: rtl/cache_init_sequencer.sv
// Sequences cache bring-up: waits for power-up and DRAM calibration, invalidates
// every tag entry, then serves whole-cache flush requests with the same clear.
module cache_init_sequencer #(
  parameter int INDEX_WIDTH     = 8,
  parameter int TAG_ENTRY_WIDTH = 20,
  parameter int TIMEOUT_WIDTH   = 24
) (
  input logic                    clk,
  input logic                    rst,
  cache_init_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT_LAUNCH, WAIT_CALIB, CLEAR, DRAIN, READY, FLUSH_WAIT, ERROR
  } state_e;

  localparam logic [INDEX_WIDTH-1:0]   IDX_ONE = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                     flush_pend_q, flush_pend_d;
  logic                     tag_we_q, tag_we_d;
  logic [INDEX_WIDTH-1:0]   tag_addr_q, tag_addr_d;
  logic                     ready_q, ready_d;
  logic                     flush_ack_q, flush_ack_d;
  logic                     calib_err_q, calib_err_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    flush_pend_d = flush_pend_q;
    flush_ack_d  = 1'b0;
    calib_err_d  = calib_err_q;
    case (state_q)
      WAIT_LAUNCH: begin
        tmo_d = '0;
        if (bus.launch) state_d = WAIT_CALIB;
      end
      WAIT_CALIB: begin
        // calib_done wins over a timeout hitting in the same cycle
        if (bus.calib_done) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (&tmo_q) begin
          state_d     = ERROR;
          calib_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      CLEAR: begin
        if (&idx_q) state_d = DRAIN;
        else        idx_d   = idx_q + IDX_ONE;
      end
      DRAIN: begin
        state_d      = READY;
        flush_ack_d  = flush_pend_q;
        flush_pend_d = 1'b0;
      end
      READY: begin
        if (bus.flush_req) begin
          state_d      = FLUSH_WAIT;
          flush_pend_d = 1'b1;
        end
      end
      FLUSH_WAIT: begin
        if (bus.cache_idle) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = WAIT_LAUNCH;
    endcase
    // outputs are decoded from the next state so they land registered
    tag_we_d   = (state_d == CLEAR);
    tag_addr_d = tag_we_d ? idx_d : '0;
    ready_d    = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LAUNCH;
      idx_q        <= '0;
      tmo_q        <= '0;
      flush_pend_q <= 1'b0;
      tag_we_q     <= 1'b0;
      tag_addr_q   <= '0;
      ready_q      <= 1'b0;
      flush_ack_q  <= 1'b0;
      calib_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      flush_pend_q <= flush_pend_d;
      tag_we_q     <= tag_we_d;
      tag_addr_q   <= tag_addr_d;
      ready_q      <= ready_d;
      flush_ack_q  <= flush_ack_d;
      calib_err_q  <= calib_err_d;
    end
  end

  assign bus.tag_we    = tag_we_q;
  assign bus.tag_addr  = tag_addr_q;
  assign bus.tag_wdata = {TAG_ENTRY_WIDTH{1'b0}};
  assign bus.ready     = ready_q;
  assign bus.flush_ack = flush_ack_q;
  assign bus.calib_err = calib_err_q;

endmodule
